// File: rtl/ring_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ring_pkg : packet field layout, traffic patterns and FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package ring_pkg;

   localparam int VALID_BIT = 48;
   localparam int TS_LSB    = 32;
   localparam int TS_W      = 16;
   localparam int SRC_LSB   = 16;
   localparam int SRC_W     = 16;
   localparam int DST_LSB   = 0;
   localparam int DST_W     = 16;

   typedef enum logic {
      PAT_COMPLEMENT = 1'b0,
      PAT_EAST       = 1'b1
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [DST_W-1:0] calc_dest(input int node_id,
                                                  input int num_nodes,
                                                  input int pattern);
      int d;
      if (pattern == int'(PAT_EAST))
         d = (node_id + 1) % num_nodes;
      else
         d = ~node_id & (num_nodes - 1);
      return DST_W'(d);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_inj_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ring_inj_fifo : injection queue with registered storage, no bypass path
// Rev 1.0
// ---------------------------------------------------------------------------
module ring_inj_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Full/empty come from the pre-edge count, so a push is refused when full
   // even if the same edge pops.
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push && !w_do_pop)
            r_count <= r_count + CW'(1);
         else if (!w_do_push && w_do_pop)
            r_count <= r_count - CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ring_traffic_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ring_traffic_gen : per-node packet generator feeding a ring router's local
// port. Optional stall statistics enabled by macro RING_TGEN_STATS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module ring_traffic_gen
   import ring_pkg::*;
#(
   parameter int NUM_NODES            = 8,
   parameter int NODE_ID              = 0,
   parameter int PACKET_SIZE          = 49,
   parameter int QUEUE_DEPTH          = 4,
   parameter int NUM_PACKETS_PER_NODE = 20,
   parameter int TRAFFIC_PATTERN      = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            clk_counter,
   input  logic [15:0]            inject_clk_ref,
   input  logic                   backpressure_rd,
   output logic [PACKET_SIZE-1:0] pkt_out,
   output logic [63:0]            total_packet_sent,
   output logic [31:0]            stall_cycles,
   output logic                   done
);

   localparam int                GCW        = $clog2(NUM_PACKETS_PER_NODE + 1);
   localparam logic [GCW-1:0]    c_NUM_PKTS = GCW'(NUM_PACKETS_PER_NODE);
   localparam logic [DST_W-1:0]  c_DEST     = calc_dest(NODE_ID, NUM_NODES, TRAFFIC_PATTERN);
   localparam logic [SRC_W-1:0]  c_SRC      = SRC_W'(NODE_ID);

   state_e                  r_state;
   logic [GCW-1:0]          r_gen_cnt;
   logic                    r_done;
   logic [PACKET_SIZE-1:0]  r_pkt_out;
   logic [63:0]             r_total;
   logic [PACKET_SIZE-1:0]  w_new_pkt;
   logic [PACKET_SIZE-1:0]  w_head;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;

   always_comb begin
      w_new_pkt                    = '0;
      w_new_pkt[VALID_BIT]         = 1'b1;
      w_new_pkt[TS_LSB +: TS_W]    = clk_counter;
      w_new_pkt[SRC_LSB +: SRC_W]  = c_SRC;
      w_new_pkt[DST_LSB +: DST_W]  = c_DEST;
   end

   // A slot that finds the queue full is simply lost; the next slot retries.
   assign w_push = (r_state == ST_RUN) && (inject_clk_ref == 16'd0) &&
                   (r_gen_cnt < c_NUM_PKTS) && !w_full;
   assign w_pop  = !w_empty && !backpressure_rd;

   ring_inj_fifo #(
      .WIDTH (PACKET_SIZE),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_new_pkt),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gen_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         if (w_push)
            r_gen_cnt <= r_gen_cnt + GCW'(1);
         case (r_state)
            ST_IDLE:  r_state <= ST_RUN;
            ST_RUN:   if (r_gen_cnt == c_NUM_PKTS) r_state <= ST_DRAIN;
            ST_DRAIN: if (w_empty) begin
                         r_state <= ST_DONE;
                         r_done  <= 1'b1;
                      end
            default:  r_state <= r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_out <= '0;
         r_total   <= '0;
      end else if (w_pop) begin
         r_pkt_out <= w_head;
         r_total   <= r_total + 64'd1;
      end else begin
         r_pkt_out <= '0;
      end
   end

`ifdef RING_TGEN_STATS_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cycles <= '0;
      else if (!w_empty && backpressure_rd && (r_stall_cycles != '1))
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;
`else
   assign stall_cycles = '0;
`endif

   assign pkt_out           = r_pkt_out;
   assign total_packet_sent = r_total;
   assign done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ring_traffic_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ring_traffic_gen: three differently parameterised instances share
// random stimulus and are compared every cycle against a queue-based model.
module tb_ring_traffic_gen;

   localparam int NI      = 3;
   localparam int NN      = 8;
   localparam int QD      = 4;
   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cc    = 16'd0;
   logic [15:0] inj   = 16'd1;
   logic        bp    = 1'b0;

   logic [48:0] pkt [NI];
   logic [63:0] tot [NI];
   logic [31:0] stl [NI];
   logic        dn  [NI];

   int checks   = 0;
   int errors   = 0;
   int inj_mode = 0;
   int last_ts  = -1;

   always #5 clk = ~clk;

   function automatic int node_of(input int i);
      case (i)
         0:       return 2;
         1:       return 3;
         default: return 7;
      endcase
   endfunction

   function automatic int pat_of(input int i);
      return (i == 2) ? 1 : 0;
   endfunction

   function automatic int npk_of(input int i);
      return (i == 1) ? 1 : 20;
   endfunction

   function automatic int dest_of(input int i);
      if (pat_of(i) == 1) return (node_of(i) + 1) % NN;
      return NN - 1 - node_of(i);
   endfunction

   ring_traffic_gen #(.NUM_NODES(8), .NODE_ID(2), .PACKET_SIZE(49), .QUEUE_DEPTH(4),
                      .NUM_PACKETS_PER_NODE(20), .TRAFFIC_PATTERN(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clk_counter(cc), .inject_clk_ref(inj),
      .backpressure_rd(bp), .pkt_out(pkt[0]), .total_packet_sent(tot[0]),
      .stall_cycles(stl[0]), .done(dn[0]));

   ring_traffic_gen #(.NUM_NODES(8), .NODE_ID(3), .PACKET_SIZE(49), .QUEUE_DEPTH(4),
                      .NUM_PACKETS_PER_NODE(1), .TRAFFIC_PATTERN(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clk_counter(cc), .inject_clk_ref(inj),
      .backpressure_rd(bp), .pkt_out(pkt[1]), .total_packet_sent(tot[1]),
      .stall_cycles(stl[1]), .done(dn[1]));

   ring_traffic_gen #(.NUM_NODES(8), .NODE_ID(7), .PACKET_SIZE(49), .QUEUE_DEPTH(4),
                      .NUM_PACKETS_PER_NODE(20), .TRAFFIC_PATTERN(1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .clk_counter(cc), .inject_clk_ref(inj),
      .backpressure_rd(bp), .pkt_out(pkt[2]), .total_packet_sent(tot[2]),
      .stall_cycles(stl[2]), .done(dn[2]));

   // Reference model: a plain queue per instance plus a phase number.
   logic [48:0] mq [NI][$];
   int          m_gen   [NI] = '{default: 0};
   int          m_phase [NI] = '{default: 0};
   longint      m_tot   [NI] = '{default: 0};
   longint      m_stall [NI] = '{default: 0};
   logic [48:0] m_out   [NI] = '{default: '0};
   int          occ;
   int          gen_pre;
   bit          do_push;
   bit          do_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            m_gen[i]   = 0;
            m_phase[i] = P_IDLE;
            m_tot[i]   = 0;
            m_stall[i] = 0;
            m_out[i]   = '0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            occ     = mq[i].size();
            gen_pre = m_gen[i];
            do_push = (m_phase[i] == P_RUN) && (inj == 16'd0) &&
                      (m_gen[i] < npk_of(i)) && (occ < QD);
            do_pop  = (occ > 0) && !bp;
            if (occ > 0 && bp) m_stall[i]++;
            if (do_pop) begin
               m_out[i] = mq[i].pop_front();
               m_tot[i]++;
            end else begin
               m_out[i] = '0;
            end
            if (do_push) begin
               mq[i].push_back({1'b1, cc, 16'(node_of(i)), 16'(dest_of(i))});
               m_gen[i]++;
            end
            case (m_phase[i])
               P_IDLE:  m_phase[i] = P_RUN;
               P_RUN:   if (gen_pre == npk_of(i)) m_phase[i] = P_DRAIN;
               P_DRAIN: if (occ == 0) m_phase[i] = P_DONE;
               default: m_phase[i] = P_DONE;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", nm, i, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [63:0] st_exp;
      if (!rst_n) last_ts = -1;
      for (int i = 0; i < NI; i++) begin
         chk("pkt_out", i, 64'(pkt[i]), 64'(m_out[i]));
         chk("total", i, tot[i], 64'(m_tot[i]));
`ifdef RING_TGEN_STATS_EN
         st_exp = (m_stall[i] > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_stall[i]);
`else
         st_exp = 64'd0;
`endif
         chk("stall", i, 64'(stl[i]), st_exp);
         chk("done", i, 64'(dn[i]), 64'(m_phase[i] == P_DONE));
      end
      if (pkt[2][48]) chk("east_wrap_dest", 2, 64'(pkt[2][15:0]), 64'd0);
      if (pkt[1][48]) chk("compl_dest_b", 1, 64'(pkt[1][15:0]), 64'd4);
      if (pkt[0][48]) begin
         chk("src_a", 0, 64'(pkt[0][31:16]), 64'd2);
         chk("dest_a", 0, 64'(pkt[0][15:0]), 64'd5);
         chk("ts_order_a", 0, 64'(int'(pkt[0][47:32]) > last_ts), 64'd1);
         last_ts = int'(pkt[0][47:32]);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      cc = cc + 16'd1;
      case (inj_mode)
         0:       inj = 16'(cc[0]);
         1:       inj = 16'($urandom_range(0, 2));
         default: inj = 16'd0;
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_until_done(input int max_cycles, input string nm);
      int n;
      n = 0;
      while (!(dn[0] && dn[1] && dn[2]) && n < max_cycles) begin
         step();
         n++;
      end
      checks++;
      if (!(dn[0] && dn[1] && dn[2])) begin
         errors++;
         $display("FAIL %s_timeout actual=%0d%0d%0d required=111", nm, dn[0], dn[1], dn[2]);
      end
   endtask

   initial begin
      int n;
      repeat (3) step();
      rst_n = 1'b1;

      // Free-running traffic, one slot every other cycle.
      run_until_done(400, "basic");
      chk("basic_total_a", 0, tot[0], 64'd20);
      chk("basic_total_b", 1, tot[1], 64'd1);
      chk("basic_total_c", 2, tot[2], 64'd20);
      repeat (6) step();
      chk("done_sticky_b", 1, 64'(dn[1]), 64'd1);

      // Backpressure held from the start: queue fills and slots are lost.
      bp = 1'b1;
      do_reset();
      repeat (20) step();
      chk("bp_hold_total_a", 0, tot[0], 64'd0);
      bp = 1'b0;
      run_until_done(600, "bp_hold");
      chk("bp_hold_final_a", 0, tot[0], 64'd20);

      // Toggle backpressure every cycle with a slot every cycle.
      inj_mode = 2;
      do_reset();
      for (int k = 0; k < 60; k++) begin
         bp = ~bp;
         step();
      end
      bp = 1'b0;
      run_until_done(400, "toggle");
      chk("toggle_total_a", 0, tot[0], 64'd20);

      // Reset mid-run after seven packets have left.
      inj_mode = 0;
      do_reset();
      n = 0;
      while (tot[0] != 64'd7 && n < 200) begin
         step();
         n++;
      end
      chk("reach_seven_a", 0, tot[0], 64'd7);
      rst_n = 1'b0;
      step();
      chk("midreset_pkt_a", 0, 64'(pkt[0]), 64'd0);
      chk("midreset_total_a", 0, tot[0], 64'd0);
      chk("midreset_done_a", 0, 64'(dn[0]), 64'd0);
      rst_n = 1'b1;
      run_until_done(400, "after_reset");
      chk("after_reset_total_a", 0, tot[0], 64'd20);

      // Random slots and random backpressure.
      inj_mode = 1;
      do_reset();
      n = 0;
      while (!(dn[0] && dn[1] && dn[2]) && n < 1500) begin
         bp = ($urandom_range(0, 3) == 0);
         step();
         n++;
      end
      bp = 1'b0;
      run_until_done(600, "random");
      chk("random_total_c", 2, tot[2], 64'd20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
